// File: rtl/adc_arbiter.sv
// rtl/adc_arbiter.sv - round-robin arbiter sharing one adc measurement engine among N_REQ requesters
// Optional watchdog abort in WAIT enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_arbiter #(
    parameter int N_REQ        = 3,
    parameter int TIMEOUT_CLKS = 40000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_sample_duration,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 adc_take_measure,
    output logic [31:0]          adc_clk_sample_duration,
    input  logic                 adc_take_measure_done,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic [1:0]           monitor
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RELEASE} state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_grant_id;
    logic [31:0]        r_dur;
    logic [N_REQ-1:0]   r_done;
    logic               r_take;
    logic               r_busy;

    logic               w_found;
    logic [1:0]         w_pick;
    int                 w_idx;
    logic [31:0]        w_dur;

    // Walk the search order backwards so the first hit after the pointer is the one kept.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = 2'(w_idx);
            end
        end
    end

    always_comb begin
        w_dur = req_sample_duration[32*int'(w_pick) +: 32];
    end

`ifdef ADC_ARB_TIMEOUT_EN
    logic [31:0]        r_cnt;
    logic [N_REQ-1:0]   r_err;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'(N_REQ - 1);
            r_grant_id <= 2'd0;
            r_dur      <= 32'd0;
            r_done     <= '0;
            r_take     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
            r_cnt      <= 32'd0;
            r_err      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_ptr      <= w_pick;
                        r_dur      <= w_dur;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_take  <= 1'b1;
                    r_busy  <= 1'b1;
`ifdef ADC_ARB_TIMEOUT_EN
                    r_cnt   <= 32'd0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_take_measure_done) begin
                        r_take  <= 1'b0;
                        r_done  <= N_REQ'(1) << r_grant_id;
                        r_state <= S_RELEASE;
`ifdef ADC_ARB_TIMEOUT_EN
                    end else if (r_cnt == 32'(TIMEOUT_CLKS - 1)) begin
                        r_take  <= 1'b0;
                        r_done  <= N_REQ'(1) << r_grant_id;
                        r_err   <= N_REQ'(1) << r_grant_id;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt   <= r_cnt + 32'd1;
`endif
                    end
                end
                S_RELEASE: begin
                    // Guard cycle: gives the adc time to return to its idle state.
                    r_done  <= '0;
                    r_busy  <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
                    r_err   <= '0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done                    = r_done;
    assign adc_take_measure        = r_take;
    assign adc_clk_sample_duration = r_dur;
    assign grant_id                = r_grant_id;
    assign busy                    = r_busy;
    assign monitor                 = {r_busy, r_take};
`ifdef ADC_ARB_TIMEOUT_EN
    assign err                     = r_err;
`else
    assign err                     = '0;
`endif

endmodule
